alu_reservation_station: RTL and testbench
==========================================

// Module: alu_reservation_station
// PURPOSE
//  Holds dispatched ALU-class µops (arith, branch, jump, load/store address) until both operands are ready.
//  Snoops the CDB (ALU and LSB result buses) to wake waiting operands.
//  Each cycle, issues at most one ready µop to arithmetic_logic_unit through registered outputs.
//  Sits between decoder/dispatch (upstream) and the ALU (downstream).
// PARAMETERS
//  RS_SIZE   16  number of entries (power of two)
//  RS_IDX_W   4  log2(RS_SIZE)
// PORTS
//  clk_in          in   1   clock
//  rst_n_in        in   1   asynchronous active-low reset
//  rdy_in          in   1   global ready; low = freeze all state
//  flush           in   1   mispredict flush from ROB
//  disp_valid      in   1   dispatch request
//  disp_opcode     in   6   internal opcode (`config.vh`); 0 = none
//  disp_q1_rdy     in   1   operand 1 value valid
//  disp_val1       in   32  operand 1 value
//  disp_q1         in   6   ROB tag producing operand 1 (used when !disp_q1_rdy)
//  disp_q2_rdy     in   1   operand 2 value valid
//  disp_val2       in   32  operand 2 value
//  disp_q2         in   6   ROB tag producing operand 2
//  disp_imm        in   32  immediate
//  disp_pc         in   32  instruction pc
//  disp_rob_index  in   6   destination ROB entry
//  rs_full         out  1   no free entry; dispatch must not be presented
//  alu_cdb_valid   in   1   ALU broadcast valid
//  alu_cdb_rob     in   6   ALU broadcast tag
//  alu_cdb_res     in   32  ALU broadcast value
//  lsb_cdb_valid   in   1   LSB (load) broadcast valid
//  lsb_cdb_rob     in   6   LSB broadcast tag
//  lsb_cdb_res     in   32  LSB broadcast value
//  iss_opcode      out  6   to ALU opcode; 0 = no issue this cycle
//  iss_val1/iss_val2/iss_imm/iss_pc  out  32  to ALU operands
//  iss_rob_index   out  6   to ALU rob_index
// BEHAVIOUR
//  Reset (rst_n_in=0, async): all busy bits cleared; iss_* = 0; rs_full = 0.
//  Per-entry state: busy, opcode, q1_rdy, val1, q1, q2_rdy, val2, q2, imm, pc, rob_index.
//  rdy_in=0: no state changes; iss_* hold their values.
//  Dispatch: at clock edge, if disp_valid && disp_opcode!=0 && !flush,
//   - writes the lowest-index free entry.
//   - When disp_valid && rs_full, the request is dropped (bench asserts this never occurs).
//  Wakeup: at each edge, every busy entry with !qN_rdy whose qN matches a valid CDB tag
//   - captures the CDB value and sets qN_rdy.
//   - ALU bus is checked before LSB; a tag never appears on both buses in one cycle.
//  Same-cycle bypass: a dispatched operand whose tag matches a CDB broadcast in the dispatch
//   cycle is written ready, with the CDB value.
//  Select: ready = busy && q1_rdy && q2_rdy; the lowest-index ready entry is selected
//   combinationally from current state. At the edge:
//   - iss_* <= that entry's fields; its busy bit is cleared.
//   - If no entry is ready, iss_opcode <= 0 (other iss_* don't-care, held).
//  Latency: a µop dispatched ready at edge E is eligible in the following cycle and on
//   iss_* after edge E+1. A µop woken at edge E issues at edge E+1 at the earliest.
//  Dispatch and issue in the same cycle are independent. An issued slot is reusable from the next edge.
//  rs_full = (number of busy entries == RS_SIZE), from registered state; it is not lowered
//   early by a same-cycle issue.
//  Flush (sync, rdy_in=1): all busy bits <- 0; iss_opcode <= 0; takes priority over dispatch,
//   wakeup and issue in that cycle.
//  Operand 2 of I-type µops: dispatch sets disp_q2_rdy=1; the RS does no opcode decoding.
// STRUCTURE
//  Shared (config.vh): opcode `defines, RS_SIZE, ROB tag width (6).
//  Sub-module rs_priority_encoder (RS_SIZE-bit vector -> valid + lowest set index):
//   - one instance for free-slot search;
//   - one instance for ready-slot select.
//  Wakeup comparators: generate loop in this module.
// TESTING
//  Dispatch ADDI (q1_rdy=1, val1=5, imm=3, rob=2) -> after next edge: iss_opcode=ADDI, iss_val1=5, iss_rob_index=2; entry freed.
//  Dispatch ADD, q1 waiting on tag 7 -> two cycles later alu_cdb {7, 0x10} -> issue next edge with iss_val1=0x10.
//  Dispatch with q2 tag 9 while lsb_cdb {9, 0xAB} is in the same cycle -> entry ready; issues next edge with iss_val2=0xAB.
//  Fill 16 non-ready entries -> rs_full=1. Wake entry 3 -> it issues, and rs_full=0 after the following edge.
//  Entries 1 and 4 are both ready -> entry 1 issues first, entry 4 issues on the next edge.
//  10 entries busy, flush=1 together with disp_valid -> all busy bits 0, iss_opcode=0, dispatch dropped; rdy_in=0 for 3 cycles -> state unchanged.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// rtl/alu_reservation_station_pkg.sv - shared sizes, opcodes, entry type and CDB snoop helper
package alu_reservation_station_pkg;

  localparam int RS_SIZE  = 16;
  localparam int RS_IDX_W = 4;
  localparam int ROB_W    = 6;
  localparam int OP_W     = 6;
  localparam int XLEN     = 32;

  localparam logic [OP_W-1:0] OP_NONE = 6'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd2;
  localparam logic [OP_W-1:0] OP_ADDI = 6'd3;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'd4;
  localparam logic [OP_W-1:0] OP_JAL  = 6'd5;
  localparam logic [OP_W-1:0] OP_LW   = 6'd6;
  localparam logic [OP_W-1:0] OP_SW   = 6'd7;

  typedef struct packed {
    logic            rdy;
    logic [XLEN-1:0] val;
  } operand_t;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic             q1_rdy;
    logic [XLEN-1:0]  val1;
    logic [ROB_W-1:0] q1;
    logic             q2_rdy;
    logic [XLEN-1:0]  val2;
    logic [ROB_W-1:0] q2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [ROB_W-1:0] rob_index;
  } rs_entry_t;

  // A waiting operand takes the first matching CDB value; the ALU bus wins over LSB.
  function automatic operand_t snoop(
    input logic             rdy,
    input logic [ROB_W-1:0] tag,
    input logic [XLEN-1:0]  val,
    input logic             alu_v,
    input logic [ROB_W-1:0] alu_tag,
    input logic [XLEN-1:0]  alu_res,
    input logic             lsb_v,
    input logic [ROB_W-1:0] lsb_tag,
    input logic [XLEN-1:0]  lsb_res
  );
    operand_t o;
    o.rdy = rdy;
    o.val = val;
    if (!rdy) begin
      if (alu_v && alu_tag == tag) begin
        o.rdy = 1'b1;
        o.val = alu_res;
      end else if (lsb_v && lsb_tag == tag) begin
        o.rdy = 1'b1;
        o.val = lsb_res;
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/alu_reservation_station_rs_priority_encoder.sv
// rtl/alu_reservation_station_rs_priority_encoder.sv - lowest-set-bit finder
module rs_priority_encoder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station with CDB wakeup and in-order-by-slot issue
module alu_reservation_station
  import alu_reservation_station_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_opcode,
  input  logic             disp_q1_rdy,
  input  logic [XLEN-1:0]  disp_val1,
  input  logic [ROB_W-1:0] disp_q1,
  input  logic             disp_q2_rdy,
  input  logic [XLEN-1:0]  disp_val2,
  input  logic [ROB_W-1:0] disp_q2,
  input  logic [XLEN-1:0]  disp_imm,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic [ROB_W-1:0] disp_rob_index,
  output logic             rs_full,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_rob,
  input  logic [XLEN-1:0]  alu_cdb_res,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_rob,
  input  logic [XLEN-1:0]  lsb_cdb_res,
  output logic [OP_W-1:0]  iss_opcode,
  output logic [XLEN-1:0]  iss_val1,
  output logic [XLEN-1:0]  iss_val2,
  output logic [XLEN-1:0]  iss_imm,
  output logic [XLEN-1:0]  iss_pc,
  output logic [ROB_W-1:0] iss_rob_index
);

  rs_entry_t            entry_q [RS_SIZE];
  logic [RS_SIZE-1:0]   busy_q;
  logic [RS_SIZE-1:0]   ready_vec;
  operand_t             op1_next [RS_SIZE];
  operand_t             op2_next [RS_SIZE];
  operand_t             disp_op1;
  operand_t             disp_op2;
  logic                 free_valid;
  logic [RS_IDX_W-1:0]  free_idx;
  logic                 sel_valid;
  logic [RS_IDX_W-1:0]  sel_idx;

  genvar g;
  generate
    for (g = 0; g < RS_SIZE; g++) begin : g_wake
      assign op1_next[g] = snoop(entry_q[g].q1_rdy, entry_q[g].q1, entry_q[g].val1,
                                 alu_cdb_valid, alu_cdb_rob, alu_cdb_res,
                                 lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_res);
      assign op2_next[g] = snoop(entry_q[g].q2_rdy, entry_q[g].q2, entry_q[g].val2,
                                 alu_cdb_valid, alu_cdb_rob, alu_cdb_res,
                                 lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_res);
      assign ready_vec[g] = busy_q[g] && entry_q[g].q1_rdy && entry_q[g].q2_rdy;
    end
  endgenerate

  // Same-cycle bypass: a broadcast seen while dispatching lands the operand ready.
  assign disp_op1 = snoop(disp_q1_rdy, disp_q1, disp_val1,
                          alu_cdb_valid, alu_cdb_rob, alu_cdb_res,
                          lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_res);
  assign disp_op2 = snoop(disp_q2_rdy, disp_q2, disp_val2,
                          alu_cdb_valid, alu_cdb_rob, alu_cdb_res,
                          lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_res);

  rs_priority_encoder #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
    .req   (~busy_q),
    .valid (free_valid),
    .idx   (free_idx)
  );

  rs_priority_encoder #(.N(RS_SIZE), .W(RS_IDX_W)) u_sel_enc (
    .req   (ready_vec),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  assign rs_full = &busy_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q        <= '0;
      entry_q       <= '{default: '0};
      iss_opcode    <= '0;
      iss_val1      <= '0;
      iss_val2      <= '0;
      iss_imm       <= '0;
      iss_pc        <= '0;
      iss_rob_index <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        busy_q     <= '0;
        iss_opcode <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i]) begin
            entry_q[i].q1_rdy <= op1_next[i].rdy;
            entry_q[i].val1   <= op1_next[i].val;
            entry_q[i].q2_rdy <= op2_next[i].rdy;
            entry_q[i].val2   <= op2_next[i].val;
          end
        end
        // Issue reads pre-wakeup state, so a woken operand waits one more edge.
        if (sel_valid) begin
          iss_opcode        <= entry_q[sel_idx].opcode;
          iss_val1          <= entry_q[sel_idx].val1;
          iss_val2          <= entry_q[sel_idx].val2;
          iss_imm           <= entry_q[sel_idx].imm;
          iss_pc            <= entry_q[sel_idx].pc;
          iss_rob_index     <= entry_q[sel_idx].rob_index;
          busy_q[sel_idx]   <= 1'b0;
        end else begin
          iss_opcode <= '0;
        end
        if (disp_valid && disp_opcode != OP_NONE && free_valid) begin
          busy_q[free_idx]  <= 1'b1;
          entry_q[free_idx] <= '{opcode:    disp_opcode,
                                 q1_rdy:    disp_op1.rdy,
                                 val1:      disp_op1.val,
                                 q1:        disp_q1,
                                 q2_rdy:    disp_op2.rdy,
                                 val2:      disp_op2.val,
                                 q2:        disp_q2,
                                 imm:       disp_imm,
                                 pc:        disp_pc,
                                 rob_index: disp_rob_index};
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - directed self-checking bench for alu_reservation_station
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             rdy_in;
  logic             flush;
  logic             disp_valid;
  logic [OP_W-1:0]  disp_opcode;
  logic             disp_q1_rdy;
  logic [XLEN-1:0]  disp_val1;
  logic [ROB_W-1:0] disp_q1;
  logic             disp_q2_rdy;
  logic [XLEN-1:0]  disp_val2;
  logic [ROB_W-1:0] disp_q2;
  logic [XLEN-1:0]  disp_imm;
  logic [XLEN-1:0]  disp_pc;
  logic [ROB_W-1:0] disp_rob_index;
  logic             rs_full;
  logic             alu_cdb_valid;
  logic [ROB_W-1:0] alu_cdb_rob;
  logic [XLEN-1:0]  alu_cdb_res;
  logic             lsb_cdb_valid;
  logic [ROB_W-1:0] lsb_cdb_rob;
  logic [XLEN-1:0]  lsb_cdb_res;
  logic [OP_W-1:0]  iss_opcode;
  logic [XLEN-1:0]  iss_val1;
  logic [XLEN-1:0]  iss_val2;
  logic [XLEN-1:0]  iss_imm;
  logic [XLEN-1:0]  iss_pc;
  logic [ROB_W-1:0] iss_rob_index;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  alu_reservation_station dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .flush          (flush),
    .disp_valid     (disp_valid),
    .disp_opcode    (disp_opcode),
    .disp_q1_rdy    (disp_q1_rdy),
    .disp_val1      (disp_val1),
    .disp_q1        (disp_q1),
    .disp_q2_rdy    (disp_q2_rdy),
    .disp_val2      (disp_val2),
    .disp_q2        (disp_q2),
    .disp_imm       (disp_imm),
    .disp_pc        (disp_pc),
    .disp_rob_index (disp_rob_index),
    .rs_full        (rs_full),
    .alu_cdb_valid  (alu_cdb_valid),
    .alu_cdb_rob    (alu_cdb_rob),
    .alu_cdb_res    (alu_cdb_res),
    .lsb_cdb_valid  (lsb_cdb_valid),
    .lsb_cdb_rob    (lsb_cdb_rob),
    .lsb_cdb_res    (lsb_cdb_res),
    .iss_opcode     (iss_opcode),
    .iss_val1       (iss_val1),
    .iss_val2       (iss_val2),
    .iss_imm        (iss_imm),
    .iss_pc         (iss_pc),
    .iss_rob_index  (iss_rob_index)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    disp_valid    = 1'b0;
    disp_opcode   = OP_NONE;
    alu_cdb_valid = 1'b0;
    lsb_cdb_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic disp(input logic [5:0] op, input logic q1r, input logic [31:0] v1,
                      input logic [5:0] q1, input logic q2r, input logic [31:0] v2,
                      input logic [5:0] q2, input logic [31:0] imm, input logic [5:0] rob);
    disp_valid     = 1'b1;
    disp_opcode    = op;
    disp_q1_rdy    = q1r;
    disp_val1      = v1;
    disp_q1        = q1;
    disp_q2_rdy    = q2r;
    disp_val2      = v2;
    disp_q2        = q2;
    disp_imm       = imm;
    disp_pc        = 32'h100 + {26'd0, rob};
    disp_rob_index = rob;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    rdy_in = 1'b1;
    idle();
    disp_q1_rdy = 0; disp_val1 = 0; disp_q1 = 0; disp_q2_rdy = 0; disp_val2 = 0;
    disp_q2 = 0; disp_imm = 0; disp_pc = 0; disp_rob_index = 0;
    alu_cdb_rob = 0; alu_cdb_res = 0; lsb_cdb_rob = 0; lsb_cdb_res = 0;
    repeat (2) tick();
    checks++;
    if (iss_opcode !== 6'd0 || rs_full !== 1'b0 || iss_val1 !== 32'd0 || iss_rob_index !== 6'd0) begin
      failures++;
      $display("FAIL reset: opcode=%0d full=%0b val1=%0h rob=%0d required 0/0/0/0",
               iss_opcode, rs_full, iss_val1, iss_rob_index);
    end
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    disp(OP_ADDI, 1'b1, 32'd5, 6'd0, 1'b1, 32'd0, 6'd0, 32'd3, 6'd2);
    tick();
    idle();
    checks++;
    if (iss_opcode !== OP_NONE) begin
      failures++;
      $display("FAIL addi_latency: opcode=%0d required 0", iss_opcode);
    end
    tick();
    checks++;
    if (iss_opcode !== OP_ADDI || iss_val1 !== 32'd5 || iss_imm !== 32'd3 ||
        iss_rob_index !== 6'd2 || iss_pc !== 32'h102) begin
      failures++;
      $display("FAIL addi_issue: op=%0d val1=%0h imm=%0h rob=%0d pc=%0h required 3/5/3/2/102",
               iss_opcode, iss_val1, iss_imm, iss_rob_index, iss_pc);
    end
    tick();
    checks++;
    if (iss_opcode !== OP_NONE) begin
      failures++;
      $display("FAIL addi_freed: opcode=%0d required 0", iss_opcode);
    end
  endtask

  task automatic test_wakeup();
    disp(OP_ADD, 1'b0, 32'd0, 6'd7, 1'b1, 32'd1, 6'd0, 32'd0, 6'd3);
    tick();
    idle();
    tick();
    checks++;
    if (iss_opcode !== OP_NONE) begin
      failures++;
      $display("FAIL wake_waiting: opcode=%0d required 0", iss_opcode);
    end
    alu_cdb_valid = 1'b1; alu_cdb_rob = 6'd7; alu_cdb_res = 32'h10;
    tick();
    idle();
    checks++;
    if (iss_opcode !== OP_NONE) begin
      failures++;
      $display("FAIL wake_edge: opcode=%0d required 0", iss_opcode);
    end
    tick();
    checks++;
    if (iss_opcode !== OP_ADD || iss_val1 !== 32'h10 || iss_val2 !== 32'd1 || iss_rob_index !== 6'd3) begin
      failures++;
      $display("FAIL wake_issue: op=%0d val1=%0h val2=%0h rob=%0d required 1/10/1/3",
               iss_opcode, iss_val1, iss_val2, iss_rob_index);
    end
    tick();
  endtask

  task automatic test_bypass();
    disp(OP_SUB, 1'b1, 32'd4, 6'd0, 1'b0, 32'd0, 6'd9, 32'd0, 6'd4);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob = 6'd9; lsb_cdb_res = 32'hAB;
    tick();
    idle();
    tick();
    checks++;
    if (iss_opcode !== OP_SUB || iss_val1 !== 32'd4 || iss_val2 !== 32'hAB || iss_rob_index !== 6'd4) begin
      failures++;
      $display("FAIL bypass: op=%0d val1=%0h val2=%0h rob=%0d required 2/4/ab/4",
               iss_opcode, iss_val1, iss_val2, iss_rob_index);
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < RS_SIZE; i++) begin
      disp(OP_ADD, 1'b0, 32'd0, 6'(20 + i), 1'b1, 32'd0, 6'd0, 32'd0, 6'(i));
      if (i == RS_SIZE - 1) begin
        checks++;
        if (rs_full !== 1'b0) begin
          failures++;
          $display("FAIL full_at_15: rs_full=%0b required 0", rs_full);
        end
      end
      tick();
    end
    idle();
    checks++;
    if (rs_full !== 1'b1) begin
      failures++;
      $display("FAIL full_at_16: rs_full=%0b required 1", rs_full);
    end
    alu_cdb_valid = 1'b1; alu_cdb_rob = 6'd23; alu_cdb_res = 32'h33;
    tick();
    idle();
    checks++;
    if (rs_full !== 1'b1 || iss_opcode !== OP_NONE) begin
      failures++;
      $display("FAIL full_wake: rs_full=%0b opcode=%0d required 1/0", rs_full, iss_opcode);
    end
    tick();
    checks++;
    if (iss_opcode !== OP_ADD || iss_rob_index !== 6'd3 || iss_val1 !== 32'h33 || rs_full !== 1'b0) begin
      failures++;
      $display("FAIL full_issue: op=%0d rob=%0d val1=%0h full=%0b required 1/3/33/0",
               iss_opcode, iss_rob_index, iss_val1, rs_full);
    end
    do_flush();
  endtask

  task automatic test_priority();
    for (int i = 0; i < 5; i++) begin
      disp(OP_BEQ, 1'b0, 32'd0, 6'(40 + i), 1'b1, 32'd0, 6'd0, 32'd0, 6'(10 + i));
      tick();
    end
    idle();
    alu_cdb_valid = 1'b1; alu_cdb_rob = 6'd41; alu_cdb_res = 32'h41;
    lsb_cdb_valid = 1'b1; lsb_cdb_rob = 6'd44; lsb_cdb_res = 32'h44;
    tick();
    idle();
    tick();
    checks++;
    if (iss_opcode !== OP_BEQ || iss_rob_index !== 6'd11 || iss_val1 !== 32'h41) begin
      failures++;
      $display("FAIL prio_first: op=%0d rob=%0d val1=%0h required 4/11/41",
               iss_opcode, iss_rob_index, iss_val1);
    end
    tick();
    checks++;
    if (iss_opcode !== OP_BEQ || iss_rob_index !== 6'd14 || iss_val1 !== 32'h44) begin
      failures++;
      $display("FAIL prio_second: op=%0d rob=%0d val1=%0h required 4/14/44",
               iss_opcode, iss_rob_index, iss_val1);
    end
    tick();
    checks++;
    if (iss_opcode !== OP_NONE) begin
      failures++;
      $display("FAIL prio_done: opcode=%0d required 0", iss_opcode);
    end
    do_flush();
  endtask

  task automatic test_flush_freeze();
    for (int i = 0; i < 10; i++) begin
      disp(OP_LW, 1'b0, 32'd0, 6'(50 + i), 1'b1, 32'd0, 6'd0, 32'd0, 6'(i));
      tick();
    end
    disp(OP_ADDI, 1'b1, 32'd1, 6'd0, 1'b1, 32'd0, 6'd0, 32'd0, 6'd20);
    flush = 1'b1;
    tick();
    idle();
    checks++;
    if (iss_opcode !== OP_NONE || rs_full !== 1'b0) begin
      failures++;
      $display("FAIL flush_edge: opcode=%0d full=%0b required 0/0", iss_opcode, rs_full);
    end
    alu_cdb_valid = 1'b1; alu_cdb_rob = 6'd50; alu_cdb_res = 32'h50;
    tick();
    idle();
    tick();
    checks++;
    if (iss_opcode !== OP_NONE) begin
      failures++;
      $display("FAIL flush_cleared: opcode=%0d rob=%0d required opcode 0", iss_opcode, iss_rob_index);
    end
    disp(OP_ADDI, 1'b1, 32'd7, 6'd0, 1'b1, 32'd0, 6'd0, 32'd0, 6'd31);
    tick();
    disp(OP_SUB, 1'b1, 32'd8, 6'd0, 1'b1, 32'd9, 6'd0, 32'd0, 6'd32);
    tick();
    idle();
    checks++;
    if (iss_opcode !== OP_ADDI || iss_rob_index !== 6'd31) begin
      failures++;
      $display("FAIL freeze_pre: op=%0d rob=%0d required 3/31", iss_opcode, iss_rob_index);
    end
    rdy_in = 1'b0;
    disp(OP_LW, 1'b1, 32'd1, 6'd0, 1'b1, 32'd0, 6'd0, 32'd0, 6'd33);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (iss_opcode !== OP_ADDI || iss_rob_index !== 6'd31 || iss_val1 !== 32'd7) begin
        failures++;
        $display("FAIL freeze_hold%0d: op=%0d rob=%0d val1=%0h required 3/31/7",
                 c, iss_opcode, iss_rob_index, iss_val1);
      end
    end
    rdy_in = 1'b1;
    idle();
    tick();
    checks++;
    if (iss_opcode !== OP_SUB || iss_rob_index !== 6'd32 || iss_val2 !== 32'd9) begin
      failures++;
      $display("FAIL freeze_resume: op=%0d rob=%0d val2=%0h required 2/32/9",
               iss_opcode, iss_rob_index, iss_val2);
    end
    tick();
    checks++;
    if (iss_opcode !== OP_NONE) begin
      failures++;
      $display("FAIL freeze_drop: op=%0d rob=%0d required opcode 0", iss_opcode, iss_rob_index);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_wakeup();
    test_bypass();
    test_full();
    test_priority();
    test_flush_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
